// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg : EX->MEM pipeline register
//
// Latches the EX-stage result (write-back target, ALU data, load/store info,
// HI/LO update) for the MEM stage. It also carries the partial product and
// cycle index used by multi-cycle madd/msub back to EX.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   stall[5:0]        pipeline stall vector (bit 3 = EX, bit 4 = MEM)
//   flush             synchronous exception flush
//   ex_*              EX-stage result fields
//   hilo_i, cnt_i     madd/msub partial product and cycle index from EX
//   mem_*             registered copies of ex_* driving the MEM stage
//   mem_valid         1 = real instruction, 0 = bubble
//   hilo_o, cnt_o     saved partial product and cycle index fed back to EX
//
// Each edge applies exactly one action, in priority order:
//   flush  -> clear everything (aborts any in-flight madd/msub)
//   bubble -> EX stalled, MEM free: clear mem_*, save hilo/cnt
//   advance-> EX not stalled: take ex_*, clear hilo/cnt
//   hold   -> EX and MEM stalled: keep everything
// ---------------------------------------------------------------------------
module ex_mem_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [ALUOP_W-1:0]  ex_aluop,
    input  logic [DATA_W-1:0]   ex_mem_addr,
    input  logic [DATA_W-1:0]   ex_reg2,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [ALUOP_W-1:0]  mem_aluop,
    output logic [DATA_W-1:0]   mem_mem_addr,
    output logic [DATA_W-1:0]   mem_reg2,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_valid,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [CNT_W-1:0]    cnt_o
);

    typedef struct packed {
        logic [ADDR_W-1:0]  wd;
        logic               wreg;
        logic [DATA_W-1:0]  wdata;
        logic [ALUOP_W-1:0] aluop;
        logic [DATA_W-1:0]  mem_addr;
        logic [DATA_W-1:0]  reg2;
        logic               whilo;
        logic [DATA_W-1:0]  hi;
        logic [DATA_W-1:0]  lo;
        logic               valid;
    } mem_bus_t;

    mem_bus_t            mem_q;
    mem_bus_t            ex_bus;
    logic [2*DATA_W-1:0] hilo_q;
    logic [CNT_W-1:0]    cnt_q;

    // Only the EX and MEM stall bits matter to this register.
    logic unused_stall;
    assign unused_stall = ^{stall[5], stall[2:0]};

    assign ex_bus = '{
        wd:       ex_wd,
        wreg:     ex_wreg,
        wdata:    ex_wdata,
        aluop:    ex_aluop,
        mem_addr: ex_mem_addr,
        reg2:     ex_reg2,
        whilo:    ex_whilo,
        hi:       ex_hi,
        lo:       ex_lo,
        valid:    1'b1
    };

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            hilo_q <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            mem_q  <= '0;
            hilo_q <= '0;
            cnt_q  <= '0;
        end else if (stall[3] && !stall[4]) begin
            // Bubble into MEM while keeping the madd/msub partial result
            // so EX can pick it up on its next cycle.
            mem_q  <= '0;
            hilo_q <= hilo_i;
            cnt_q  <= cnt_i;
        end else if (!stall[3]) begin
            // Also covers the non-monotonic stall[4]=1 & stall[3]=0 case.
            mem_q  <= ex_bus;
            hilo_q <= '0;
            cnt_q  <= '0;
        end
    end

    assign mem_wd       = mem_q.wd;
    assign mem_wreg     = mem_q.wreg;
    assign mem_wdata    = mem_q.wdata;
    assign mem_aluop    = mem_q.aluop;
    assign mem_mem_addr = mem_q.mem_addr;
    assign mem_reg2     = mem_q.reg2;
    assign mem_whilo    = mem_q.whilo;
    assign mem_hi       = mem_q.hi;
    assign mem_lo       = mem_q.lo;
    assign mem_valid    = mem_q.valid;
    assign hilo_o       = hilo_q;
    assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_reg : self-checking bench for ex_mem_reg
//
// A behavioural model tracks what the MEM stage should currently see (the
// last instruction EX handed over, a bubble, or nothing after reset/flush)
// and what partial product EX has parked. A compare process checks every
// output against it on each falling edge; directed steps add literal checks.
// ---------------------------------------------------------------------------
module tb_ex_mem_reg;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int ALUOP_W = 8;
    localparam int CNT_W   = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [5:0]          stall = '0;
    logic                flush = 1'b0;
    logic [ADDR_W-1:0]   ex_wd = '0;
    logic                ex_wreg = 1'b0;
    logic [DATA_W-1:0]   ex_wdata = '0;
    logic [ALUOP_W-1:0]  ex_aluop = '0;
    logic [DATA_W-1:0]   ex_mem_addr = '0;
    logic [DATA_W-1:0]   ex_reg2 = '0;
    logic                ex_whilo = 1'b0;
    logic [DATA_W-1:0]   ex_hi = '0;
    logic [DATA_W-1:0]   ex_lo = '0;
    logic [2*DATA_W-1:0] hilo_i = '0;
    logic [CNT_W-1:0]    cnt_i = '0;
    logic [ADDR_W-1:0]   mem_wd;
    logic                mem_wreg;
    logic [DATA_W-1:0]   mem_wdata;
    logic [ALUOP_W-1:0]  mem_aluop;
    logic [DATA_W-1:0]   mem_mem_addr;
    logic [DATA_W-1:0]   mem_reg2;
    logic                mem_whilo;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic                mem_valid;
    logic [2*DATA_W-1:0] hilo_o;
    logic [CNT_W-1:0]    cnt_o;

    ex_mem_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_aluop(ex_aluop),
        .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_aluop(mem_aluop),
        .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_valid(mem_valid),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- model ----------------
    // What MEM holds: an instruction record (valid) or an empty slot.
    typedef struct {
        bit          valid;
        int unsigned wd, wreg, wdata, aluop, addr, reg2, whilo, hi, lo;
    } instr_t;

    instr_t          m_mem;
    longint unsigned m_hilo;
    int unsigned     m_cnt;

    function automatic instr_t empty_slot();
        instr_t e;
        e.valid = 0; e.wd = 0; e.wreg = 0; e.wdata = 0; e.aluop = 0;
        e.addr = 0; e.reg2 = 0; e.whilo = 0; e.hi = 0; e.lo = 0;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mem  <= empty_slot();
            m_hilo <= 0;
            m_cnt  <= 0;
        end else if (flush) begin
            m_mem  <= empty_slot();
            m_hilo <= 0;
            m_cnt  <= 0;
        end else if (stall[3] == 1'b0) begin
            instr_t n;
            n.valid = 1; n.wd = ex_wd; n.wreg = ex_wreg; n.wdata = ex_wdata;
            n.aluop = ex_aluop; n.addr = ex_mem_addr; n.reg2 = ex_reg2;
            n.whilo = ex_whilo; n.hi = ex_hi; n.lo = ex_lo;
            m_mem  <= n;
            m_hilo <= 0;
            m_cnt  <= 0;
        end else if (stall[4] == 1'b0) begin
            m_mem  <= empty_slot();
            m_hilo <= hilo_i;
            m_cnt  <= cnt_i;
        end
        // EX and MEM both stalled: the model simply keeps what it has.
    end

    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m.wd",    64'(mem_wd),       64'(m_mem.wd));
            chk("m.wreg",  64'(mem_wreg),     64'(m_mem.wreg));
            chk("m.wdata", 64'(mem_wdata),    64'(m_mem.wdata));
            chk("m.aluop", 64'(mem_aluop),    64'(m_mem.aluop));
            chk("m.addr",  64'(mem_mem_addr), 64'(m_mem.addr));
            chk("m.reg2",  64'(mem_reg2),     64'(m_mem.reg2));
            chk("m.whilo", 64'(mem_whilo),    64'(m_mem.whilo));
            chk("m.hi",    64'(mem_hi),       64'(m_mem.hi));
            chk("m.lo",    64'(mem_lo),       64'(m_mem.lo));
            chk("m.valid", 64'(mem_valid),    64'(m_mem.valid));
            chk("m.hilo",  hilo_o,            m_hilo);
            chk("m.cnt",   64'(cnt_o),        64'(m_cnt));
            if (!rst && stall[4] && !stall[3])
                $display("note: non-monotonic stall vector %b at %0t", stall, $time);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic [31:0] wdata, input logic wreg);
        ex_wd = wd; ex_wdata = wdata; ex_wreg = wreg;
        ex_aluop = 8'(wdata[7:0] ^ 8'h5A);
        ex_mem_addr = wdata + 32'h100;
        ex_reg2 = ~wdata;
    endtask

    logic [5:0] stall_tab [16] = '{6'b000000, 6'b000011, 6'b001111, 6'b011111,
                                   6'b011111, 6'b000111, 6'b001111, 6'b000000,
                                   6'b111111, 6'b001111, 6'b000000, 6'b011111,
                                   6'b000001, 6'b001111, 6'b111111, 6'b000000};

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        cmp_en = 1;
        // reset state
        chk("rst.valid", 64'(mem_valid), 64'h0);
        chk("rst.wd",    64'(mem_wd),    64'h0);
        step();
        rst = 1'b0;

        // T2 advance
        set_ex(5'd5, 32'hDEADBEEF, 1'b1);
        step();
        chk("t2.wd",    64'(mem_wd),    64'd5);
        chk("t2.wdata", 64'(mem_wdata), 64'hDEADBEEF);
        chk("t2.wreg",  64'(mem_wreg),  64'h1);
        chk("t2.valid", 64'(mem_valid), 64'h1);
        chk("t2.hilo",  hilo_o,         64'h0);
        chk("t2.cnt",   64'(cnt_o),     64'h0);

        // T4 hold with changing ex_*
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            set_ex(5'(9 + i), 32'h1234 + 32'(i), 1'b0);
            hilo_i = 64'hABCD_0000 + 64'(i);
            cnt_i = 2'd3;
            step();
            chk("t4.wd",    64'(mem_wd),    64'd5);
            chk("t4.wdata", 64'(mem_wdata), 64'hDEADBEEF);
            chk("t4.valid", 64'(mem_valid), 64'h1);
            chk("t4.hilo",  hilo_o,         64'h0);
        end

        // T3 bubble
        stall = 6'b001111;
        hilo_i = 64'h0000_0001_0000_0002;
        cnt_i = 2'd1;
        step();
        chk("t3.wreg",  64'(mem_wreg),  64'h0);
        chk("t3.wd",    64'(mem_wd),    64'h0);
        chk("t3.valid", 64'(mem_valid), 64'h0);
        chk("t3.hilo",  hilo_o,         64'h0000_0001_0000_0002);
        chk("t3.cnt",   64'(cnt_o),     64'h1);

        // hold keeps the saved partial product
        stall = 6'b011111;
        hilo_i = 64'hFFFF_FFFF_FFFF_FFFF;
        cnt_i = 2'd2;
        step();
        chk("hold.hilo", hilo_o,     64'h0000_0001_0000_0002);
        chk("hold.cnt",  64'(cnt_o), 64'h1);

        // T6 madd: bubble then advance
        stall = 6'b001111;
        hilo_i = 64'h0000_0005_0000_0007;
        cnt_i = 2'd1;
        step();
        chk("t6.b.hilo", hilo_o, 64'h0000_0005_0000_0007);
        stall = 6'b000000;
        set_ex(5'd0, 32'h0, 1'b0);
        ex_whilo = 1'b1; ex_hi = 32'h12; ex_lo = 32'h34;
        hilo_i = 64'h0000_0005_0000_0007;
        cnt_i = 2'd2;
        step();
        chk("t6.whilo", 64'(mem_whilo), 64'h1);
        chk("t6.hi",    64'(mem_hi),    64'h12);
        chk("t6.lo",    64'(mem_lo),    64'h34);
        chk("t6.hilo",  hilo_o,         64'h0);
        chk("t6.cnt",   64'(cnt_o),     64'h0);
        ex_whilo = 1'b0; ex_hi = '0; ex_lo = '0;

        // T5 flush beats bubble, with a partial product parked first
        stall = 6'b001111;
        hilo_i = 64'h1111_2222_3333_4444;
        cnt_i = 2'd1;
        step();
        flush = 1'b1;
        hilo_i = 64'h5555_6666_7777_8888;
        step();
        flush = 1'b0;
        chk("t5.hilo",  hilo_o,         64'h0);
        chk("t5.cnt",   64'(cnt_o),     64'h0);
        chk("t5.valid", 64'(mem_valid), 64'h0);
        chk("t5.wd",    64'(mem_wd),    64'h0);

        // flush also clears a loaded instruction
        stall = 6'b000000;
        set_ex(5'd17, 32'hCAFEF00D, 1'b1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5b.wdata", 64'(mem_wdata), 64'h0);
        chk("t5b.wreg",  64'(mem_wreg),  64'h0);

        // non-monotonic stall vector behaves as advance
        stall = 6'b010000;
        set_ex(5'd7, 32'h0BAD_0007, 1'b1);
        step();
        chk("ill.wd",    64'(mem_wd),    64'd7);
        chk("ill.valid", 64'(mem_valid), 64'h1);

        // directed stall table sweep, checked by the model
        for (int i = 0; i < 16; i++) begin
            stall = stall_tab[i];
            set_ex(5'(i * 3), 32'h0101_0101 * 32'(i + 1), 1'(i % 2));
            ex_whilo = 1'(i % 3 == 0);
            ex_hi = 32'h1000 + 32'(i);
            ex_lo = 32'h2000 + 32'(i);
            hilo_i = 64'h0123_4567_89AB_CDEF + 64'(i);
            cnt_i = 2'(i);
            step();
        end

        // T1 asynchronous reset mid-cycle with outputs loaded
        stall = 6'b000000;
        set_ex(5'd21, 32'h7777_1234, 1'b1);
        step();
        chk("t1.pre", 64'(mem_wd), 64'd21);
        #2 rst = 1'b1;
        #1;
        chk("t1.wd",    64'(mem_wd),    64'h0);
        chk("t1.wdata", 64'(mem_wdata), 64'h0);
        chk("t1.wreg",  64'(mem_wreg),  64'h0);
        chk("t1.valid", 64'(mem_valid), 64'h0);
        step();
        chk("t1.held", 64'(mem_valid), 64'h0);
        rst = 1'b0;
        step();
        chk("t1.after", 64'(mem_wd), 64'd21);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
